// File: rtl/slave_spi_resp_sched_pkg.sv
// ---------------------------------------------------------------------------
// slave_spi_resp_sched_pkg
// Purpose : shared types and constants for the SPI slave response scheduler.
//   - sched_state_e : scheduler FSM states (IDLE, ARB, LOAD, BUSY)
//   - STATS_W       : width of the optional statistics counters
//   - sat_inc       : saturating increment used by those counters
// Optional feature macro used by the scheduler: SLAVE_SPI_RESP_SCHED_STATS_EN
// ---------------------------------------------------------------------------
package slave_spi_resp_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    LOAD = 2'd2,
    BUSY = 2'd3
  } sched_state_e;

  localparam int STATS_W = 16;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (v == {STATS_W{1'b1}}) ? v : v + {{(STATS_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/slave_spi_rr_arbiter.sv
// ---------------------------------------------------------------------------
// slave_spi_rr_arbiter
// Purpose : combinational rotate-priority pick. The requester at index
//           i_ptr has highest priority, then i_ptr+1, ... wrapping modulo
//           NUM_REQ.
// Ports   :
//   i_req_valid  in  NUM_REQ  per-requester valid
//   i_ptr        in  IDX_W    index holding highest priority (< NUM_REQ)
//   o_grant      out NUM_REQ  one-hot winner (all zero if none valid)
//   o_index      out IDX_W    winner index (0 if none valid)
//   o_any_valid  out 1        at least one requester valid
// ---------------------------------------------------------------------------
module slave_spi_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_index,
  output logic               o_any_valid
);

  always_comb begin
    int         idx;
    logic [IDX_W-1:0] cand;
    idx         = 0;
    cand        = '0;
    o_index     = '0;
    o_any_valid = 1'b0;
    o_grant     = '0;
    // Walk from the lowest priority offset to the highest so the last hit
    // (smallest offset from i_ptr) wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(i_ptr) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = IDX_W'(idx);
      if (i_req_valid[cand]) begin
        o_index     = cand;
        o_any_valid = 1'b1;
      end
    end
    if (o_any_valid) begin
      o_grant[o_index] = 1'b1;
    end
  end

endmodule

// File: rtl/slave_spi_resp_scheduler.sv
// ---------------------------------------------------------------------------
// slave_spi_resp_scheduler
// Purpose : shares the SPI slave MISO response path between NUM_REQ
//           requesters, one word per chip-select frame. On each frame-start
//           pulse a round-robin winner's word (or IDLE_PATTERN on underrun)
//           is loaded into the slave shift engine.
// Ports   :
//   i_pclk            in  1                  clock
//   i_areset          in  1                  synchronous reset, active-low
//   i_req_valid       in  NUM_REQ            per-requester word available
//   i_req_data        in  NUM_REQ*DATA_WIDTH packed words, req i at [i*DW +: DW]
//   o_req_ready       out NUM_REQ            one-hot acceptance pulse (ARB cycle)
//   i_frame_start     in  1                  CS asserted pulse
//   i_frame_done      in  1                  CS deasserted pulse
//   o_eng_load_valid  out 1                  load request to shift engine
//   o_eng_load_data   out DATA_WIDTH         word to shift out
//   i_eng_load_ready  in  1                  engine accepted load
//   o_grant_id        out $clog2(NUM_REQ)    current frame owner
//   o_grant_vld       out 1                  o_grant_id meaningful
//   o_busy            out 1                  FSM not idle
//   o_underrun        out 1                  pulse: IDLE_PATTERN selected
//   o_abort           out 1                  pulse: frame ended before load accept
//   o_proto_err       out 1                  pulse: frame_start at an illegal time
//   o_frame_cnt / o_underrun_cnt / o_abort_cnt  (only with
//           SLAVE_SPI_RESP_SCHED_STATS_EN) 16-bit saturating statistics
// ---------------------------------------------------------------------------
module slave_spi_resp_scheduler
  import slave_spi_resp_sched_pkg::*;
#(
  parameter int                    NUM_REQ      = 4,
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN = '1,
  localparam int                   IDX_W        = $clog2(NUM_REQ)
) (
  input  logic                          i_pclk,
  input  logic                          i_areset,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  input  logic                          i_frame_start,
  input  logic                          i_frame_done,
  output logic                          o_eng_load_valid,
  output logic [DATA_WIDTH-1:0]         o_eng_load_data,
  input  logic                          i_eng_load_ready,
  output logic [IDX_W-1:0]              o_grant_id,
  output logic                          o_grant_vld,
  output logic                          o_busy,
  output logic                          o_underrun,
  output logic                          o_abort,
`ifdef SLAVE_SPI_RESP_SCHED_STATS_EN
  output logic [STATS_W-1:0]            o_frame_cnt,
  output logic [STATS_W-1:0]            o_underrun_cnt,
  output logic [STATS_W-1:0]            o_abort_cnt,
`endif
  output logic                          o_proto_err
);

  sched_state_e            r_state;
  sched_state_e            w_state_next;
  logic [IDX_W-1:0]        r_ptr;
  logic [DATA_WIDTH-1:0]   r_load_data;
  logic [IDX_W-1:0]        r_grant_id;
  logic                    r_grant_vld;
  logic                    r_underrun;
  logic                    r_abort;
  logic                    r_proto_err;

  logic [NUM_REQ-1:0]      w_grant_oh;
  logic [IDX_W-1:0]        w_index;
  logic                    w_any_valid;
  logic [IDX_W-1:0]        w_ptr_next;
  logic [DATA_WIDTH-1:0]   w_req_word [NUM_REQ];
  logic                    w_in_arb;
  logic                    w_abort_next;
  logic                    w_proto_next;
  logic                    w_frame_end;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_word
      assign w_req_word[gi] = i_req_data[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  slave_spi_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .i_req_valid (i_req_valid),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant_oh),
    .o_index     (w_index),
    .o_any_valid (w_any_valid)
  );

  assign w_in_arb   = (r_state == ARB);
  // Pointer moves to the slot just after the winner, wrapping at NUM_REQ
  // (NUM_REQ need not be a power of two).
  assign w_ptr_next = (w_index == IDX_W'(NUM_REQ - 1)) ? '0 : w_index + IDX_W'(1);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (i_frame_start) w_state_next = ARB;
      ARB:  w_state_next = i_frame_done ? IDLE : LOAD;
      LOAD: begin
        // A load accepted in the same cycle the frame ends still counts.
        if (i_eng_load_ready) begin
          w_state_next = i_frame_done ? IDLE : BUSY;
        end else if (i_frame_done) begin
          w_state_next = IDLE;
        end
      end
      BUSY: if (i_frame_done) w_state_next = i_frame_start ? ARB : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign w_abort_next = i_frame_done &
                        (w_in_arb | ((r_state == LOAD) & ~i_eng_load_ready));
  assign w_proto_next = i_frame_start &
                        (w_in_arb | (r_state == LOAD) |
                         ((r_state == BUSY) & ~i_frame_done));
  assign w_frame_end  = i_frame_done & ((r_state == LOAD) | (r_state == BUSY));

  always_ff @(posedge i_pclk) begin
    if (!i_areset) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_load_data <= '0;
      r_grant_id  <= '0;
      r_grant_vld <= 1'b0;
      r_underrun  <= 1'b0;
      r_abort     <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_abort     <= w_abort_next;
      r_proto_err <= w_proto_next;
      r_underrun  <= w_in_arb & ~w_any_valid;
      if (w_in_arb) begin
        if (w_any_valid) begin
          r_load_data <= w_req_word[w_index];
          r_grant_id  <= w_index;
          r_ptr       <= w_ptr_next;
          // The word is consumed even if the frame ends right now, but no
          // frame is owned afterwards.
          r_grant_vld <= ~i_frame_done;
        end else begin
          r_load_data <= IDLE_PATTERN;
          r_grant_vld <= 1'b0;
        end
      end else if (w_frame_end) begin
        r_grant_vld <= 1'b0;
      end
    end
  end

  assign o_req_ready      = w_in_arb ? w_grant_oh : '0;
  assign o_eng_load_valid = (r_state == LOAD);
  assign o_eng_load_data  = r_load_data;
  assign o_grant_id       = r_grant_id;
  assign o_grant_vld      = r_grant_vld;
  assign o_busy           = (r_state != IDLE);
  assign o_underrun       = r_underrun;
  assign o_abort          = r_abort;
  assign o_proto_err      = r_proto_err;

`ifdef SLAVE_SPI_RESP_SCHED_STATS_EN
  logic [STATS_W-1:0] r_frame_cnt;
  logic [STATS_W-1:0] r_underrun_cnt;
  logic [STATS_W-1:0] r_abort_cnt;

  always_ff @(posedge i_pclk) begin
    if (!i_areset) begin
      r_frame_cnt    <= '0;
      r_underrun_cnt <= '0;
      r_abort_cnt    <= '0;
    end else begin
      if ((w_state_next == ARB) && (r_state != ARB)) begin
        r_frame_cnt <= sat_inc(r_frame_cnt);
      end
      if (w_in_arb && !w_any_valid) begin
        r_underrun_cnt <= sat_inc(r_underrun_cnt);
      end
      if (w_abort_next) begin
        r_abort_cnt <= sat_inc(r_abort_cnt);
      end
    end
  end

  assign o_frame_cnt    = r_frame_cnt;
  assign o_underrun_cnt = r_underrun_cnt;
  assign o_abort_cnt    = r_abort_cnt;
`endif

endmodule

// File: tb/tb_slave_spi_resp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_slave_spi_resp_scheduler
// Directed frames push the expected load (ready vector, word, grant, underrun)
// into a queue; a monitor pops and compares each time the engine load
// request rises. Control-path pulses are checked inline by the stimulus.
// ---------------------------------------------------------------------------
module tb_slave_spi_resp_scheduler;

  logic        clk;
  logic        areset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        frame_start;
  logic        frame_done;
  logic        eng_load_valid;
  logic [7:0]  eng_load_data;
  logic        eng_load_ready;
  logic [1:0]  grant_id;
  logic        grant_vld;
  logic        busy;
  logic        underrun;
  logic        abort_p;
  logic        proto_err;
`ifdef SLAVE_SPI_RESP_SCHED_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] underrun_cnt;
  logic [15:0] abort_cnt;
`endif

  slave_spi_resp_scheduler #(
    .NUM_REQ      (4),
    .DATA_WIDTH   (8),
    .IDLE_PATTERN (8'hFF)
  ) dut (
    .i_pclk           (clk),
    .i_areset         (areset),
    .i_req_valid      (req_valid),
    .i_req_data       (req_data),
    .o_req_ready      (req_ready),
    .i_frame_start    (frame_start),
    .i_frame_done     (frame_done),
    .o_eng_load_valid (eng_load_valid),
    .o_eng_load_data  (eng_load_data),
    .i_eng_load_ready (eng_load_ready),
    .o_grant_id       (grant_id),
    .o_grant_vld      (grant_vld),
    .o_busy           (busy),
    .o_underrun       (underrun),
    .o_abort          (abort_p),
`ifdef SLAVE_SPI_RESP_SCHED_STATS_EN
    .o_frame_cnt      (frame_cnt),
    .o_underrun_cnt   (underrun_cnt),
    .o_abort_cnt      (abort_cnt),
`endif
    .o_proto_err      (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] rdy;
    logic [7:0] data;
    logic [1:0] id;
    logic       vld;
    logic       un;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h at %0t", name, act, $time);
    end
  endtask

  // Monitor: compare each load presentation against the scoreboard head.
  logic [3:0] mon_prev_ready = '0;
  logic       mon_prev_valid = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (areset && eng_load_valid && !mon_prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_load: got data 0x%0h expected no load at %0t", eng_load_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_req_ready", {28'd0, mon_prev_ready}, {28'd0, e.rdy});
          check("tx_load_data", {24'd0, eng_load_data}, {24'd0, e.data});
          check("tx_grant_vld", {31'd0, grant_vld}, {31'd0, e.vld});
          if (e.vld) check("tx_grant_id", {30'd0, grant_id}, {30'd0, e.id});
          check("tx_underrun", {31'd0, underrun}, {31'd0, e.un});
        end
      end
      mon_prev_valid = areset & eng_load_valid;
      mon_prev_ready = req_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a frame and step into LOAD; expectation pushed for the monitor.
  task automatic run_frame(input logic [3:0] v, input logic [3:0] e_rdy, input logic [7:0] e_d,
                           input logic [1:0] e_id, input logic e_vld, input logic e_un);
    exp_t e;
    e.rdy = e_rdy; e.data = e_d; e.id = e_id; e.vld = e_vld; e.un = e_un;
    exp_q.push_back(e);
    req_valid   = v;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    tick();
    check("load_latency", {31'd0, eng_load_valid}, 32'd1);
  endtask

  task automatic accept();
    eng_load_ready = 1'b1;
    tick();
    eng_load_ready = 1'b0;
    check("busy_after_accept", {31'd0, busy}, 32'd1);
  endtask

  task automatic end_frame();
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("idle_after_done", {31'd0, busy}, 32'd0);
    check("grant_vld_after_done", {31'd0, grant_vld}, 32'd0);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_load_valid", {31'd0, eng_load_valid}, 32'd0);
    check("rst_load_data", {24'd0, eng_load_data}, 32'd0);
    check("rst_grant", {29'd0, grant_vld, grant_id}, 32'd0);
    check("rst_req_ready", {28'd0, req_ready}, 32'd0);
    check("rst_pulses", {29'd0, underrun, abort_p, proto_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b0; req_valid = '0; frame_start = 1'b0; frame_done = 1'b0;
    eng_load_ready = 1'b0;
    req_data = {8'h44, 8'hA5, 8'h22, 8'h11};  // req3..req0
    repeat (3) tick();
    check_reset_outputs();
    areset = 1'b1;
    tick();

    // Rotation from reset: 0,1,2,3,0
    run_frame(4'b1111, 4'b0001, 8'h11, 2'd0, 1'b1, 1'b0); accept(); end_frame();
    run_frame(4'b1111, 4'b0010, 8'h22, 2'd1, 1'b1, 1'b0); accept(); end_frame();
    run_frame(4'b1111, 4'b0100, 8'hA5, 2'd2, 1'b1, 1'b0); accept(); end_frame();
    run_frame(4'b1111, 4'b1000, 8'h44, 2'd3, 1'b1, 1'b0); accept(); end_frame();
    run_frame(4'b1111, 4'b0001, 8'h11, 2'd0, 1'b1, 1'b0); accept(); end_frame();

    // Single requester 2
    run_frame(4'b0100, 4'b0100, 8'hA5, 2'd2, 1'b1, 1'b0); accept(); end_frame();

    // Underrun, then pointer must still favour requester 3
    run_frame(4'b0000, 4'b0000, 8'hFF, 2'd0, 1'b0, 1'b1); accept(); end_frame();
    run_frame(4'b1111, 4'b1000, 8'h44, 2'd3, 1'b1, 1'b0); accept(); end_frame();

    // Abort: frame_done while in LOAD with no engine accept
    run_frame(4'b0010, 4'b0010, 8'h22, 2'd1, 1'b1, 1'b0);
    frame_done = 1'b1;
    tick();
    frame_done = 1'b0;
    check("abort_pulse", {31'd0, abort_p}, 32'd1);
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_load_valid", {31'd0, eng_load_valid}, 32'd0);
    tick();
    check("abort_one_cycle", {31'd0, abort_p}, 32'd0);

    // done + ready in the same LOAD cycle: accepted, no abort
    run_frame(4'b0110, 4'b0100, 8'hA5, 2'd2, 1'b1, 1'b0);
    frame_done = 1'b1; eng_load_ready = 1'b1;
    tick();
    frame_done = 1'b0; eng_load_ready = 1'b0;
    check("done_ready_no_abort", {31'd0, abort_p}, 32'd0);
    check("done_ready_idle", {31'd0, busy}, 32'd0);

    // Protocol error then back-to-back frames
    run_frame(4'b1111, 4'b1000, 8'h44, 2'd3, 1'b1, 1'b0); accept();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("proto_err_busy", {31'd0, proto_err}, 32'd1);
    check("proto_err_still_busy", {31'd0, busy}, 32'd1);
    begin
      exp_t e;
      e.rdy = 4'b0001; e.data = 8'h11; e.id = 2'd0; e.vld = 1'b1; e.un = 1'b0;
      exp_q.push_back(e);
    end
    frame_done = 1'b1; frame_start = 1'b1;
    tick();
    frame_done = 1'b0; frame_start = 1'b0;
    check("b2b_in_arb_ready", {28'd0, req_ready}, 32'h1);
    check("b2b_no_proto_err", {31'd0, proto_err}, 32'd0);
    tick();
    check("b2b_load_valid", {31'd0, eng_load_valid}, 32'd1);
    accept();

    // Mid-frame reset in BUSY, then pointer must restart at requester 0
    areset = 1'b0;
    tick();
    check_reset_outputs();
    areset = 1'b1;
    tick();
    run_frame(4'b1111, 4'b0001, 8'h11, 2'd0, 1'b1, 1'b0); accept(); end_frame();

    repeat (2) tick();
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
